// File: rtl/fast9_mem_pkg.sv
// fast9_mem_pkg: shared pixel SRAM geometry and requester ids for the FAST9 memory path
package fast9_mem_pkg;
  localparam int SRAM_ADDR_WIDTH = 15;
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int FRAME_PIXELS = 21600;
  typedef enum logic {
    REQ_W = 1'b0,
    REQ_R = 1'b1
  } req_id_e;
endpackage

// File: rtl/sram_rd_valid_pipe.sv
// sram_rd_valid_pipe: LATENCY-deep valid shift register with synchronous clear
module sram_rd_valid_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clock,
  input  logic i_clear,
  input  logic i_valid,
  output logic o_valid
);
  logic [LATENCY-1:0] r_sr;
  always_ff @(posedge clock) begin
    if (i_clear) r_sr <= '0;
    else begin
      r_sr[0] <= i_valid;
      for (int i = 1; i < LATENCY; i++) r_sr[i] <= r_sr[i-1];
    end
  end
  assign o_valid = r_sr[LATENCY-1];
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin write/read arbiter for the single-port pixel SRAM
module sram_arbiter
  import fast9_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = SRAM_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_q,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_wren,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  req_id_e r_last;
  logic    w_pipe_valid;
  // on a tie the requester that did not win last time is served
  always_comb begin
    rd_gnt       = !reset && rd_req && (!wr_req || r_last == REQ_W);
    wr_gnt       = !reset && wr_req && !rd_gnt;
    sram_wren    = wr_gnt;
    sram_address = wr_gnt ? wr_addr : rd_gnt ? rd_addr : '0;
    sram_data    = wr_gnt ? wr_data : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) r_last <= REQ_W;
    else if (wr_gnt || rd_gnt) r_last <= rd_gnt ? REQ_R : REQ_W;
  end
  sram_rd_valid_pipe #(.LATENCY(READ_LATENCY)) u_pipe (
    .clock   (clock),
    .i_clear (reset),
    .i_valid (rd_gnt),
    .o_valid (w_pipe_valid)
  );
  // the stage already in flight when reset rises must not leak out
  assign rd_valid = w_pipe_valid && !reset;
  assign rd_q     = sram_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random + directed check of sram_arbiter at read latencies 1 and 2
module tb_sram_arbiter;
  logic clock = 0, reset = 1;
  logic wr_req = 0, rd_req = 0;
  logic [14:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0;
  logic wr_gnt1, rd_gnt1, rd_valid1, sram_wren1, wr_gnt2, rd_gnt2, rd_valid2, sram_wren2;
  logic [7:0] rd_q1, sram_data1, sram_q1, rd_q2, sram_data2, sram_q2;
  logic [14:0] sram_address1, sram_address2;
  always #5 clock = ~clock;
  sram_arbiter #(.READ_LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt1), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1), .rd_valid(rd_valid1),
    .rd_q(rd_q1), .sram_address(sram_address1), .sram_data(sram_data1), .sram_wren(sram_wren1),
    .sram_q(sram_q1));
  sram_arbiter #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt2), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt2), .rd_valid(rd_valid2),
    .rd_q(rd_q2), .sram_address(sram_address2), .sram_data(sram_data2), .sram_wren(sram_wren2),
    .sram_q(sram_q2));
  // SRAM models: registered address, latency 1 and latency 2 output
  logic [7:0] mem1 [32768];
  logic [7:0] mem2 [32768];
  logic [14:0] a1, a2;
  logic [7:0] q2r;
  always @(posedge clock) begin
    if (sram_wren1) mem1[sram_address1] <= sram_data1;
    a1 <= sram_address1;
  end
  assign sram_q1 = mem1[a1];
  always @(posedge clock) begin
    if (sram_wren2) mem2[sram_address2] <= sram_data2;
    a2 <= sram_address2;
    q2r <= mem2[a2];
  end
  assign sram_q2 = q2r;
  // reference model
  typedef struct {int due; int data;} rd_t;
  rd_t q1[$];
  rd_t q2[$];
  int exp_mem [32768];
  bit tie_to_r = 1;
  bit last_gw, last_gr;
  int cyc = 0, n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask
  task automatic cycle(input bit rst, input bit wq, input int wa, input int wd, input bit rq, input int ra);
    bit gw, gr, v1, v2;
    reset = rst; wr_req = wq; wr_addr = wa[14:0]; wr_data = wd[7:0]; rd_req = rq; rd_addr = ra[14:0];
    @(negedge clock);
    gw = 0; gr = 0;
    if (!rst) begin
      if (wq && rq) begin gr = tie_to_r; gw = !tie_to_r; end
      else begin gw = wq; gr = rq; end
    end
    check("wr_gnt1", wr_gnt1, gw);
    check("rd_gnt1", rd_gnt1, gr);
    check("wr_gnt2", wr_gnt2, gw);
    check("rd_gnt2", rd_gnt2, gr);
    check("sram_wren", sram_wren1, gw);
    check("sram_address", sram_address1, gw ? wa : gr ? ra : 0);
    check("sram_data", sram_data1, gw ? wd : 0);
    if (rst) begin q1.delete(); q2.delete(); end
    v1 = q1.size() > 0 && q1[0].due == cyc;
    v2 = q2.size() > 0 && q2[0].due == cyc;
    check("rd_valid_l1", rd_valid1, v1);
    check("rd_valid_l2", rd_valid2, v2);
    if (v1) begin check("rd_q_l1", rd_q1, q1[0].data); void'(q1.pop_front()); end
    if (v2) begin check("rd_q_l2", rd_q2, q2[0].data); void'(q2.pop_front()); end
    if (rst) tie_to_r = 1;
    if (gw) begin exp_mem[wa] = wd; tie_to_r = 1; end
    if (gr) begin
      q1.push_back('{cyc + 1, exp_mem[ra]});
      q2.push_back('{cyc + 2, exp_mem[ra]});
      tie_to_r = 0;
    end
    last_gw = gw; last_gr = gr;
    cyc++;
    @(posedge clock); #1;
  endtask
  initial begin
    bit wq, rq, rst;
    int wa, wd, ra;
    for (int i = 0; i < 32768; i++) begin mem1[i] = 0; mem2[i] = 0; exp_mem[i] = 0; end
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) cycle(1, 1, 5, 'h99, 1, 7);
    for (int i = 0; i < 8; i++) cycle(0, 1, 10, 'h55, 1, 11);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, i, 'h30 + i, 0, 0);
    cycle(0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, i);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 3, 'hAA, 0, 0);
    cycle(0, 0, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    wq = 0; rq = 0; wa = 0; wd = 0; ra = 0;
    for (int i = 0; i < 500; i++) begin
      rst = $urandom_range(49) == 0;
      if (!(wq && !last_gw && $urandom_range(9) != 0)) begin
        wq = $urandom_range(1) == 1; wa = $urandom_range(15); wd = $urandom_range(255);
      end
      if (!(rq && !last_gr && $urandom_range(9) != 0)) begin
        rq = $urandom_range(1) == 1; ra = $urandom_range(15);
      end
      cycle(rst, wq, wa, wd, rq, ra);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
